// File: rtl/minimax_mem_pkg.sv
// Shared definitions for the minimax memory front end: the exit register
// address, the request-kind encoding and the flat-address decode helpers.
package minimax_mem_pkg;

   localparam logic [31:0] EXIT_ADDR_DEFAULT = 32'hfffffffc;

   typedef enum logic [1:0] {
      REQ_NONE,
      REQ_STORE,
      REQ_LOAD,
      REQ_FETCH
   } req_kind_t;

   // Bank index: the bits just above the in-bank word address.
   function automatic logic [31:0] addr_bank(input logic [31:0] a,
                                             input int unsigned wb,
                                             input int unsigned bb);
      return (a >> (wb + 2)) & ((32'd1 << bb) - 32'd1);
   endfunction

   // Word address inside one bank.
   function automatic logic [31:0] addr_word(input logic [31:0] a,
                                             input int unsigned wb);
      return (a >> 2) & ((32'd1 << wb) - 32'd1);
   endfunction

   // True when the byte address falls inside the SRAM-backed space.
   function automatic logic addr_in_range(input logic [31:0] a,
                                          input int unsigned banks,
                                          input int unsigned words);
      return {32'h0, a} < (64'(banks) * 64'(words) * 64'd4);
   endfunction

endpackage

// File: rtl/minimax_fetch_buffer.sv
// One-entry instruction fetch buffer: remembers the last word fetched from
// SRAM and its in-space word key. A store to that word, or a store that
// collides with the word being filled, leaves the entry invalid.
module minimax_fetch_buffer #(
   parameter int unsigned KW = 11
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [KW-1:0] lookup_key,
   output logic          hit,
   output logic [31:0]   hit_word,
   input  logic          fill_en,
   input  logic [KW-1:0] fill_key,
   input  logic [31:0]   fill_word,
   input  logic          store_en,
   input  logic [KW-1:0] store_key
);

   logic          buf_valid;
   logic [KW-1:0] buf_key;
   logic [31:0]   buf_word;

   assign hit      = buf_valid && (buf_key == lookup_key);
   assign hit_word = buf_word;

   // Fill from the SRAM return, or drop the entry when a store touches it
   always_ff @(posedge clk) begin
      if (!reset) begin
         buf_valid <= 1'b0;
         buf_key   <= '0;
         buf_word  <= '0;
      end else if (fill_en) begin
         buf_key   <= fill_key;
         buf_word  <= fill_word;
         buf_valid <= !(store_en && (store_key == fill_key));
      end else if (store_en && (store_key == buf_key)) begin
         buf_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/minimax_sram_arbiter.sv
// Single-port SRAM arbiter for the minimax core: one SRAM access per cycle,
// priority store > load > fetch, plus a memory-mapped exit register.
// Optional fetch buffer: define MINIMAX_ARB_FETCH_BUFFER_EN.
// Handshake: d_ready is combinational and high whenever a store or load is
// presented (data never stalls); loads/fetches answer with rvalid/inst_valid
// exactly one cycle after acceptance; a fetch that is not served simply
// produces no inst_valid and the core keeps inst_req/inst_addr asserted.
module minimax_sram_arbiter
   import minimax_mem_pkg::*;
#(
   parameter int unsigned PC_BITS    = 13,
   parameter int unsigned BANKS      = 4,
   parameter int unsigned BANK_WORDS = 512,
   parameter logic [31:0] EXIT_ADDR  = EXIT_ADDR_DEFAULT
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [PC_BITS-1:0]            inst_addr,
   input  logic                          inst_req,
   output logic [15:0]                   inst,
   output logic                          inst_valid,
   input  logic [31:0]                   addr,
   input  logic [31:0]                   wdata,
   input  logic [3:0]                    wmask,
   input  logic                          rreq,
   output logic                          d_ready,
   output logic [31:0]                   rdata,
   output logic                          rvalid,
   output logic [BANKS-1:0]              sram_en,
   output logic [$clog2(BANK_WORDS)-1:0] sram_addr,
   output logic [31:0]                   sram_wdata,
   output logic [3:0]                    sram_wmask,
   input  logic [BANKS*32-1:0]           sram_rdata,
   output logic                          exit_valid,
   output logic [31:0]                   exit_code
);

   localparam int unsigned WB = $clog2(BANK_WORDS);
   localparam int unsigned BB = $clog2(BANKS);
   localparam int unsigned BW = (BB > 0) ? BB : 1;
   localparam int unsigned KW = WB + BB;

   req_kind_t     kind;
   logic [31:0]   fetch_addr;
   logic [31:0]   cmd_addr;
   logic [BW-1:0] cmd_bank;
   logic [BW-1:0] fetch_bank;
   logic          cmd_ok;
   logic          fetch_hit;
   logic          is_exit;
   logic [BW-1:0] rd_bank;
   logic          rd_oor;
   logic [BW-1:0] if_bank;
   logic          if_half;
   logic          if_buf;
   logic [31:0]   rdata_q;
   logic [31:0]   rdata_live;
   logic [31:0]   if_word;
   logic [31:0]   buf_word_q;
   logic [15:0]   inst_q;
   logic [15:0]   inst_live;

   // Fetch addresses are zero-extended; decode keeps only in-space bits.
   assign fetch_addr = 32'(inst_addr);

   // Pick the single request that owns the SRAM port this cycle
   always_comb begin
      kind = REQ_NONE;
      if (!reset)                    kind = REQ_NONE;
      else if (|wmask)               kind = REQ_STORE;
      else if (rreq)                 kind = REQ_LOAD;
      else if (inst_req && !fetch_hit) kind = REQ_FETCH;
   end

   assign cmd_addr   = (kind == REQ_FETCH) ? fetch_addr : addr;
   assign cmd_bank   = BW'(addr_bank(cmd_addr, WB, BB));
   assign fetch_bank = BW'(addr_bank(fetch_addr, WB, BB));
   assign cmd_ok     = (kind == REQ_FETCH) || addr_in_range(addr, BANKS, BANK_WORDS);
   assign is_exit    = (kind == REQ_STORE) && (addr == EXIT_ADDR) && (wmask == 4'hf);

   // Drive the one-hot bank enable for an in-range winner
   always_comb begin
      sram_en = '0;
      for (int i = 0; i < BANKS; i++) begin
         sram_en[i] = (kind != REQ_NONE) && cmd_ok && (cmd_bank == BW'(i));
      end
   end

   assign sram_addr  = WB'(addr_word(cmd_addr, WB));
   assign sram_wdata = wdata;
   assign sram_wmask = (kind == REQ_STORE) ? wmask : 4'h0;
   assign d_ready    = reset && ((|wmask) || rreq);

   // Response data comes straight from the SRAM return, held when idle.
   assign rdata_live = rd_oor ? 32'h0 : sram_rdata[int'(rd_bank)*32 +: 32];
   assign if_word    = if_buf ? buf_word_q : sram_rdata[int'(if_bank)*32 +: 32];
   assign inst_live  = if_half ? if_word[31:16] : if_word[15:0];
   assign rdata      = rvalid ? rdata_live : rdata_q;
   assign inst       = inst_valid ? inst_live : inst_q;

   // Track accepted requests so their responses appear one cycle later
   always_ff @(posedge clk) begin
      if (!reset) begin
         rvalid     <= 1'b0;
         inst_valid <= 1'b0;
         exit_valid <= 1'b0;
         exit_code  <= '0;
         rd_bank    <= '0;
         rd_oor     <= 1'b0;
         if_bank    <= '0;
         if_half    <= 1'b0;
         if_buf     <= 1'b0;
         rdata_q    <= '0;
         inst_q     <= '0;
      end else begin
         rvalid     <= (kind == REQ_LOAD);
         rd_bank    <= cmd_bank;
         rd_oor     <= !cmd_ok;
         inst_valid <= (kind == REQ_FETCH) || (inst_req && fetch_hit);
         if_bank    <= fetch_bank;
         if_half    <= inst_addr[1];
         if_buf     <= inst_req && fetch_hit;
         exit_valid <= is_exit;
         if (is_exit)    exit_code <= wdata;
         if (rvalid)     rdata_q   <= rdata_live;
         if (inst_valid) inst_q    <= inst_live;
      end
   end

`ifdef MINIMAX_ARB_FETCH_BUFFER_EN
   logic          buf_hit;
   logic [31:0]   buf_rdata;
   logic [KW-1:0] if_key;

   minimax_fetch_buffer #(.KW(KW)) u_fetch_buffer (
      .clk        (clk),
      .reset      (reset),
      .lookup_key (KW'(fetch_addr >> 2)),
      .hit        (buf_hit),
      .hit_word   (buf_rdata),
      .fill_en    (inst_valid && !if_buf),
      .fill_key   (if_key),
      .fill_word  (if_word),
      .store_en   ((kind == REQ_STORE) && cmd_ok),
      .store_key  (KW'(addr >> 2))
   );

   assign fetch_hit = buf_hit;

   // Remember which word an SRAM fetch reads and snapshot buffer hits
   always_ff @(posedge clk) begin
      if (!reset) begin
         if_key     <= '0;
         buf_word_q <= '0;
      end else begin
         if (kind == REQ_FETCH)     if_key     <= KW'(fetch_addr >> 2);
         if (inst_req && fetch_hit) buf_word_q <= buf_rdata;
      end
   end
`else
   assign fetch_hit  = 1'b0;
   assign buf_word_q = '0;
`endif

endmodule
